// File: rtl/sha_key_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sha_key_fifo_if
// Brief    : Digest-capture / AES-key handshake bundle for sha_key_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface sha_key_fifo_if #(
  parameter int DEPTH  = 4,
  parameter int KEY_W  = 128,
  parameter int DCNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              sha_valid;
  logic [31:0]       sha_id;
  logic [255:0]      sha_digest;
  logic              flush;
  logic              key_valid;
  logic              key_ready;
  logic [KEY_W-1:0]  key_data;
  logic [31:0]       key_id;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DCNT_W-1:0] drop_cnt;

  // Producer/consumer side of the buffer.
  modport master (
    output sha_valid, sha_id, sha_digest, flush, key_ready,
    input  key_valid, key_data, key_id, level, overflow, drop_cnt
  );

  // Buffer side.
  modport slave (
    input  sha_valid, sha_id, sha_digest, flush, key_ready,
    output key_valid, key_data, key_id, level, overflow, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sha_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sha_key_fifo
// Brief    : Captures SHA-256 digests into a FIFO and presents them as AES
//            keys. Macro KEY_FOLD_EN selects XOR-folding for 128-bit keys.
// Revision : 1.0 - initial release
// ============================================================================
module sha_key_fifo #(
  parameter int DEPTH  = 4,
  parameter int KEY_W  = 128,
  parameter int DCNT_W = 16
) (
  input  logic           clk,
  input  logic           rstn,
  sha_key_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 32 + 256;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  if ((KEY_W != 128) && (KEY_W != 256)) begin : g_bad_key_w
    $error("sha_key_fifo: KEY_W must be 128 or 256");
  end
  if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
    $error("sha_key_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              key_valid_q, key_valid_d;
  logic              overflow_q, overflow_d;
  logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              push, pop, drop, wr_en;
  logic [ENT_W-1:0]  head;
  logic [255:0]      head_dig;

  assign pop  = key_valid_q && bus.key_ready;
  assign push = bus.sha_valid && ((level_q < FULL_LVL) || pop);
  assign drop = bus.sha_valid && (level_q == FULL_LVL) && !pop;

  // Flush wins over everything, including a coincident digest.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + DCNT_W'(1);
        end
      end
    end
    key_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is cleared on reset so the show-ahead outputs read zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wptr_q] <= {bus.sha_id, bus.sha_digest};
    end
  end

  assign head          = mem_q[rptr_q];
  assign head_dig      = head[255:0];
  assign bus.key_id    = head[ENT_W-1:256];
  assign bus.key_valid = key_valid_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

  if (KEY_W == 256) begin : g_key256
    assign bus.key_data = head_dig;
  end else begin : g_key128
`ifdef KEY_FOLD_EN
    assign bus.key_data = head_dig[255:128] ^ head_dig[127:0];
`else
    assign bus.key_data = head_dig[255:128];
`endif
  end
endmodule
`default_nettype wire

// File: tb/tb_sha_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_key_fifo
// Brief    : Self-checking bench for sha_key_fifo with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_key_fifo;
  localparam int DEPTH  = 4;
  localparam int KEY_W  = 128;
  localparam int DCNT_W = 16;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
`ifdef KEY_FOLD_EN
  localparam logic [127:0] ABC_KEY = 128'h0a7b771c1916b576f551bfbfafae378e;
`else
  localparam logic [127:0] ABC_KEY = 128'hba7816bf8f01cfea414140de5dae2223;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sha_key_fifo_if #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DCNT_W(DCNT_W)) bus ();

  sha_key_fifo #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DCNT_W(DCNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: an ordered list of accepted {id, digest} entries.
  logic [287:0] m_q [$];
  logic         m_ovf  = 1'b0;
  int           m_drop = 0;
  logic         m_pop;

  function automatic logic [KEY_W-1:0] key_of(input logic [255:0] d);
`ifdef KEY_FOLD_EN
    return d[255:128] ^ d[127:0];
`else
    return d[255:128];
`endif
  endfunction

  function automatic logic [255:0] mkdig(input logic [31:0] id);
    return {{4{id * 32'h9E3779B9}}, {4{id ^ 32'h5A5A5A5A}}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
      m_ovf  <= 1'b0;
      m_drop <= 0;
    end else if (bus.flush) begin
      m_q.delete();
    end else begin
      m_pop = (m_q.size() != 0) && bus.key_ready;
      if (bus.sha_valid && m_q.size() == DEPTH && !m_pop) begin
        m_ovf <= 1'b1;
        if (m_drop < (1 << DCNT_W) - 1) m_drop <= m_drop + 1;
      end
      if (m_pop) void'(m_q.pop_front());
      if (bus.sha_valid && (m_q.size() < DEPTH))
        m_q.push_back({bus.sha_id, bus.sha_digest});
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("key_valid", 256'(bus.key_valid), 256'(m_q.size() != 0));
      chk("level", 256'(bus.level), 256'(m_q.size()));
      chk("overflow", 256'(bus.overflow), 256'(m_ovf));
      chk("drop_cnt", 256'(bus.drop_cnt), 256'(m_drop));
      if (m_q.size() != 0) begin
        chk("key_id", 256'(bus.key_id), 256'(m_q[0][287:256]));
        chk("key_data", 256'(bus.key_data), 256'(key_of(m_q[0][255:0])));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] id, input logic [255:0] d);
    bus.sha_valid  = 1'b1;
    bus.sha_id     = id;
    bus.sha_digest = d;
    step();
    bus.sha_valid  = 1'b0;
  endtask

  initial begin
    int popped [$];
    bus.sha_valid  = 1'b0;
    bus.sha_id     = '0;
    bus.sha_digest = '0;
    bus.flush      = 1'b0;
    bus.key_ready  = 1'b0;

    step(); step();
    chk("rst_key_valid", 256'(bus.key_valid), 256'(0));
    chk("rst_level", 256'(bus.level), 256'(0));
    chk("rst_key_data", 256'(bus.key_data), 256'(0));
    chk("rst_key_id", 256'(bus.key_id), 256'(0));
    chk("rst_overflow", 256'(bus.overflow), 256'(0));
    chk("rst_drop_cnt", 256'(bus.drop_cnt), 256'(0));
    rstn = 1'b1;
    step();

    // Single "abc" digest, consumer always ready.
    bus.key_ready = 1'b1;
    send(32'd5, ABC_DIG);
    chk("t1_valid", 256'(bus.key_valid), 256'(1));
    chk("t1_id", 256'(bus.key_id), 256'(5));
    chk("t1_key", 256'(bus.key_data), 256'(ABC_KEY));
    step();
    chk("t1_valid_one_cycle", 256'(bus.key_valid), 256'(0));

    // Fill to DEPTH with consumer stalled.
    bus.key_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i), mkdig(32'(i)));
    chk("t2_level", 256'(bus.level), 256'(4));
    chk("t2_overflow", 256'(bus.overflow), 256'(0));

    // Overflow while full.
    send(32'd9, mkdig(32'd9));
    chk("t3_overflow", 256'(bus.overflow), 256'(1));
    chk("t3_drop_cnt", 256'(bus.drop_cnt), 256'(1));
    chk("t3_head_id", 256'(bus.key_id), 256'(1));
    chk("t3_level", 256'(bus.level), 256'(4));

    // Push and pop together while full, then drain.
    bus.key_ready = 1'b1;
    send(32'd7, mkdig(32'd7));
    chk("t4_level", 256'(bus.level), 256'(4));
    chk("t4_drop_cnt", 256'(bus.drop_cnt), 256'(1));
    for (int n = 0; n < 20 && bus.key_valid; n++) begin
      popped.push_back(int'(bus.key_id));
      step();
    end
    chk("t4_pop_count", 256'(popped.size()), 256'(4));
    if (popped.size() == 4) begin
      chk("t4_pop0", 256'(popped[0]), 256'(2));
      chk("t4_pop1", 256'(popped[1]), 256'(3));
      chk("t4_pop2", 256'(popped[2]), 256'(4));
      chk("t4_pop3", 256'(popped[3]), 256'(7));
    end
    chk("t4_level_end", 256'(bus.level), 256'(0));

    // Flush with three entries and a coincident digest.
    bus.key_ready = 1'b0;
    for (int i = 10; i <= 12; i++) send(32'(i), mkdig(32'(i)));
    bus.flush = 1'b1;
    send(32'd13, mkdig(32'd13));
    bus.flush = 1'b0;
    chk("t5_level", 256'(bus.level), 256'(0));
    chk("t5_valid", 256'(bus.key_valid), 256'(0));
    chk("t5_drop_cnt", 256'(bus.drop_cnt), 256'(1));
    chk("t5_overflow", 256'(bus.overflow), 256'(1));

    // Async reset in the middle of a drain.
    send(32'd20, mkdig(32'd20));
    send(32'd21, mkdig(32'd21));
    send(32'd22, mkdig(32'd22));
    bus.key_ready = 1'b1;
    step();
    #1 rstn = 1'b0;
    #1;
    chk("t5_rst_valid", 256'(bus.key_valid), 256'(0));
    chk("t5_rst_level", 256'(bus.level), 256'(0));
    chk("t5_rst_data", 256'(bus.key_data), 256'(0));
    chk("t5_rst_id", 256'(bus.key_id), 256'(0));
    chk("t5_rst_overflow", 256'(bus.overflow), 256'(0));
    chk("t5_rst_drop", 256'(bus.drop_cnt), 256'(0));
    step();
    rstn = 1'b1;
    step(); step();
    chk("post_rst_level", 256'(bus.level), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
